pair_reduce_eng: RTL

- Consumer end of the pairing queue and producer of its input stream; evaluates a polynomial by Estrin-style pairwise reduction.
- Pops {a_left, a_right, cnt} pairs from the queue and computes a_left + a_right * x^(2^cnt) in a fixed-latency pipeline.
- Sends each result back to the queue with level cnt+1.
- Also injects leaf coefficients at level 0, and holds the x-power table.

---
 rtl/pair_reduce_eng.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pair_reduce_eng.sv
// Pairwise (Estrin) polynomial reduction engine: pops {a_left, a_right, cnt} pairs,
// emits a_left + a_right * x^(2^cnt) at level cnt+1, and injects leaf coefficients at level 0.
// Latency: pop at t -> out_vld at t+MUL_LAT+1; leaf accepted at t -> out_vld at t+1.
// Backpressure: none downstream; results always win the output register and block leaves that cycle.
// Ports: clk/rst_n; x_in/x_load/tbl_rdy (power table); leaf_* (leaf input); que_* (pair pop);
//        out_* (to queue); err (sticky illegal level). Optional stat_leaf/stat_pair outputs
//        exist only when PAIR_REDUCE_STAT_EN is defined.
module pair_reduce_eng #(
  parameter int WID_D   = 32,
  parameter int CNT_W   = 5,
  parameter int ORD_NUM = 30,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WID_D-1:0] x_in,
  input  logic             x_load,
  output logic             tbl_rdy,
  input  logic [WID_D-1:0] leaf_data,
  input  logic             leaf_vld,
  output logic             leaf_rdy,
  input  logic [WID_D-1:0] que_a_left,
  input  logic [WID_D-1:0] que_a_right,
  input  logic [CNT_W-1:0] que_cnt,
  input  logic             que_vld,
  output logic             que_rdy,
  output logic [WID_D-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_vld,
  output logic             err
`ifdef PAIR_REDUCE_STAT_EN
  ,
  output logic [15:0]      stat_leaf,
  output logic [15:0]      stat_pair
`endif
);

  localparam int IDXW = (ORD_NUM > 1) ? $clog2(ORD_NUM) : 1;
  localparam logic [CNT_W-1:0] ORD_C  = CNT_W'(ORD_NUM);
  localparam logic [IDXW-1:0]  K_LAST = IDXW'(ORD_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_POWGEN, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  k_q, k_d;
  logic [WID_D-1:0] x_q;
  logic [WID_D-1:0] pow_q [ORD_NUM];

  logic [IDXW-1:0]  kprev;
  logic [IDXW-1:0]  pidx;
  logic [WID_D-1:0] sq;
  logic [WID_D-1:0] res;
  logic             pop, legal, last_vld, leaf_hs;

  logic [MUL_LAT-1:0] pv_q;
  logic [WID_D-1:0]   pd_q [MUL_LAT];
  logic [CNT_W-1:0]   pc_q [MUL_LAT];

  logic             out_vld_q;
  logic [WID_D-1:0] out_data_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             err_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (x_load) begin
      // Reload restarts table generation from any state.
      state_d = S_POWGEN;
      k_d     = '0;
    end else begin
      case (state_q)
        S_POWGEN: begin
          if (k_q == K_LAST) begin
            state_d = S_RUN;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tbl_rdy  = (state_q == S_RUN);
  assign que_rdy  = (state_q == S_RUN);
  assign last_vld = pv_q[MUL_LAT-1];
  assign leaf_rdy = (state_q == S_RUN) & ~last_vld;
  assign leaf_hs  = leaf_vld & leaf_rdy;

  // ---------------- Power table: pow[k] = x^(2^k) ----------------
  always_comb begin
    kprev = (k_q == '0) ? '0 : k_q - 1'b1;
    sq    = pow_q[kprev] * pow_q[kprev];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      for (int i = 0; i < ORD_NUM; i++) pow_q[i] <= '0;
    end else begin
      if (x_load) x_q <= x_in;
      else if (state_q == S_POWGEN) pow_q[k_q] <= (k_q == '0) ? x_q : sq;
    end
  end

  // ---------------- Pair pop and multiply-add pipeline ----------------
  assign pop   = que_vld & que_rdy;
  assign legal = (que_cnt < ORD_C);
  assign pidx  = IDXW'(que_cnt);
  // Index is only meaningful when legal; illegal pops never enter the pipeline.
  assign res   = que_a_left + que_a_right * pow_q[pidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        pd_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= pop & legal & ~x_load;
      if (pop) begin
        pd_q[0] <= res;
        pc_q[0] <= que_cnt + 1'b1;
      end
      for (int i = 1; i < MUL_LAT; i++) begin
        pv_q[i] <= pv_q[i-1] & ~x_load;
        pd_q[i] <= pd_q[i-1];
        pc_q[i] <= pc_q[i-1];
      end
    end
  end

  // ---------------- Output register and error flag ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      out_vld_q <= 1'b0;
      if (!x_load) begin
        if (last_vld) begin
          out_vld_q  <= 1'b1;
          out_data_q <= pd_q[MUL_LAT-1];
          out_cnt_q  <= pc_q[MUL_LAT-1];
        end else if (leaf_hs) begin
          out_vld_q  <= 1'b1;
          out_data_q <= leaf_data;
          out_cnt_q  <= '0;
        end
      end
      if (pop & ~legal) err_q <= 1'b1;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_cnt  = out_cnt_q;
  assign err      = err_q;

`ifdef PAIR_REDUCE_STAT_EN
  logic [15:0] stat_leaf_q, stat_pair_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_leaf_q <= '0;
      stat_pair_q <= '0;
    end else if (x_load) begin
      stat_leaf_q <= '0;
      stat_pair_q <= '0;
    end else begin
      if (leaf_hs)       stat_leaf_q <= stat_leaf_q + 16'd1;
      if (pop & legal)   stat_pair_q <= stat_pair_q + 16'd1;
    end
  end

  assign stat_leaf = stat_leaf_q;
  assign stat_pair = stat_pair_q;
`endif

endmodule
